// File: rtl/btb_pkg.sv
// Shared constants for the branch target buffer: counter encodings, walker
// states and fixed entry field widths.
package btb_pkg;

  localparam int VALID_W = 1;
  localparam int CTR_W   = 2;

  localparam logic [CTR_W-1:0] CTR_SNT = 2'b00;
  localparam logic [CTR_W-1:0] CTR_WNT = 2'b01;
  localparam logic [CTR_W-1:0] CTR_WT  = 2'b10;
  localparam logic [CTR_W-1:0] CTR_STT = 2'b11;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  function automatic int entry_width(input int addr_w, input int idx_w);
    return VALID_W + (addr_w - idx_w) + addr_w + CTR_W;
  endfunction

endpackage

// File: rtl/branch_target_buffer_if.sv
// Fetch/decode/branch-unit bundle of the branch target buffer.
// BTB_STATS_EN adds the HitCount/MissCount statistics outputs.
interface branch_target_buffer_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] FetchPC;
  logic              PredTaken;
  logic [ADDR_W-1:0] PredTarget;
  logic              Stall;
  logic              FlushPipe;
  logic              PcMatchValid;
  logic              JumpTaken;
  logic [1:0]        CtrlState;
  logic              WriteEnable;
  logic [1:0]        CtrlOut;
  logic [ADDR_W-1:0] UpdPC;
  logic [ADDR_W-1:0] UpdTarget;
  logic              Invalidate;
  logic              Busy;
`ifdef BTB_STATS_EN
  logic [15:0]       HitCount;
  logic [15:0]       MissCount;
`endif

  modport master (
    output FetchPC, Stall, FlushPipe, WriteEnable, CtrlOut, UpdPC, UpdTarget, Invalidate,
    input  PredTaken, PredTarget, PcMatchValid, JumpTaken, CtrlState, Busy
`ifdef BTB_STATS_EN
    , input HitCount, MissCount
`endif
  );

  modport slave (
    input  FetchPC, Stall, FlushPipe, WriteEnable, CtrlOut, UpdPC, UpdTarget, Invalidate,
    output PredTaken, PredTarget, PcMatchValid, JumpTaken, CtrlState, Busy
`ifdef BTB_STATS_EN
    , output HitCount, MissCount
`endif
  );

endinterface

// File: rtl/btb_ram.sv
// Entry storage: one synchronous write port, one asynchronous read port.
module btb_ram #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [1 << AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit counters, fetch/decode pipeline register and
// a table-clear walker. BTB_STATS_EN enables saturating hit/miss counters.
module branch_target_buffer
  import btb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int IDX_W  = 4
) (
  input logic CLK,
  input logic RST_N,
  branch_target_buffer_if.slave bus
);

  localparam int TAG_W   = ADDR_W - IDX_W;
  localparam int DEPTH   = 1 << IDX_W;
  localparam int ENTRY_W = entry_width(ADDR_W, IDX_W);

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] target;
    logic [CTR_W-1:0]  ctr;
  } entry_t;

  state_t           state_reg;
  logic [IDX_W-1:0] ptr_reg;
  logic             pipe_valid_reg;
  logic             pipe_taken_reg;
  logic [CTR_W-1:0] pipe_ctr_reg;

  logic             idle;
  logic             upd_we;
  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic [IDX_W-1:0] upd_idx;
  entry_t           upd_entry;
  entry_t           rd_entry;
  entry_t           look_entry;
  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  entry_t           wr_data;
  logic             hit;
  logic             look_taken;
  logic [CTR_W-1:0] look_ctr;

  assign idle      = (state_reg == ST_IDLE);
  assign upd_we    = idle && bus.WriteEnable;
  assign fetch_idx = bus.FetchPC[IDX_W-1:0];
  assign fetch_tag = bus.FetchPC[ADDR_W-1:IDX_W];
  assign upd_idx   = bus.UpdPC[IDX_W-1:0];

  assign upd_entry = '{valid: 1'b1, tag: bus.UpdPC[ADDR_W-1:IDX_W],
                       target: bus.UpdTarget, ctr: bus.CtrlOut};

  // The walker owns the single write port while clearing; updates are dropped.
  assign wr_en   = upd_we || !idle;
  assign wr_addr = idle ? upd_idx : ptr_reg;
  assign wr_data = idle ? upd_entry : '0;

  btb_ram #(.WIDTH(ENTRY_W), .AW(IDX_W)) u_ram (
    .clk   (CLK),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (fetch_idx),
    .rdata (rd_entry)
  );

  // Write-first: a same-cycle update to the fetched index is seen by the lookup.
  assign look_entry = (upd_we && (upd_idx == fetch_idx)) ? upd_entry : rd_entry;

  assign hit        = idle && look_entry.valid && (look_entry.tag == fetch_tag);
  assign look_taken = hit && look_entry.ctr[1];
  assign look_ctr   = hit ? look_entry.ctr : CTR_SNT;

  assign bus.PredTaken    = look_taken;
  assign bus.PredTarget   = hit ? look_entry.target : '0;
  assign bus.Busy         = !idle;
  assign bus.PcMatchValid = pipe_valid_reg;
  assign bus.JumpTaken    = pipe_taken_reg;
  assign bus.CtrlState    = pipe_ctr_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= ST_CLEAR;
      ptr_reg   <= '0;
    end else begin
      case (state_reg)
        ST_CLEAR: begin
          if (bus.Invalidate) begin
            ptr_reg <= '0;
          end else begin
            ptr_reg <= ptr_reg + 1'b1;
            if (ptr_reg == IDX_W'(DEPTH - 1)) state_reg <= ST_IDLE;
          end
        end
        default: begin
          if (bus.Invalidate) begin
            state_reg <= ST_CLEAR;
            ptr_reg   <= '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pipe_valid_reg <= 1'b0;
      pipe_taken_reg <= 1'b0;
      pipe_ctr_reg   <= CTR_SNT;
    end else if (bus.FlushPipe) begin
      pipe_valid_reg <= 1'b0;
      pipe_taken_reg <= 1'b0;
      pipe_ctr_reg   <= CTR_SNT;
    end else if (!bus.Stall) begin
      pipe_valid_reg <= hit;
      pipe_taken_reg <= look_taken;
      pipe_ctr_reg   <= look_ctr;
    end
  end

`ifdef BTB_STATS_EN
  logic [15:0] hit_count_reg;
  logic [15:0] miss_count_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else if (idle && !bus.Stall) begin
      if (hit) begin
        if (hit_count_reg != 16'hFFFF) hit_count_reg <= hit_count_reg + 16'd1;
      end else begin
        if (miss_count_reg != 16'hFFFF) miss_count_reg <= miss_count_reg + 16'd1;
      end
    end
  end

  assign bus.HitCount  = hit_count_reg;
  assign bus.MissCount = miss_count_reg;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboarded bench for branch_target_buffer: expectations queued at drive
// time, popped and compared when outputs are sampled on the falling edge.
module tb_branch_target_buffer;

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  typedef struct {
    logic [15:0] fetch;
    logic        we;
    logic [15:0] upd;
    logic [15:0] utgt;
    logic [1:0]  ctrl;
    logic        stall;
    logic        flush;
    logic        inval;
  } stim_t;

  typedef struct {
    logic        cf;
    logic        pt;
    logic [15:0] tgt;
    logic        cp;
    logic        pmv;
    logic        jt;
    logic [1:0]  cs;
    logic        cb;
    logic        busy;
  } exp_t;

  logic CLK;
  logic RST_N;
  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  branch_target_buffer_if #(.ADDR_W(16)) bus ();

  branch_target_buffer #(.ADDR_W(16), .IDX_W(4)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic stim_t st(input logic [15:0] fetch, input logic we, input logic [15:0] upd,
                               input logic [15:0] utgt, input logic [1:0] ctrl,
                               input logic stall, input logic flush, input logic inval);
    st = '{fetch, we, upd, utgt, ctrl, stall, flush, inval};
  endfunction

  function automatic exp_t ex(input logic cf, input logic pt, input logic [15:0] tgt,
                              input logic cp, input logic pmv, input logic jt,
                              input logic [1:0] cs, input logic cb, input logic busy);
    ex = '{cf, pt, tgt, cp, pmv, jt, cs, cb, busy};
  endfunction

  task automatic apply(input stim_t s);
    bus.FetchPC     = s.fetch;
    bus.WriteEnable = s.we;
    bus.UpdPC       = s.upd;
    bus.UpdTarget   = s.utgt;
    bus.CtrlOut     = s.ctrl;
    bus.Stall       = s.stall;
    bus.FlushPipe   = s.flush;
    bus.Invalidate  = s.inval;
  endtask

  task automatic test_reset();
    exp_t e;
    RST_N = 1'b0;
    apply(st(16'h0005, N, 16'h0, 16'h0, 2'b00, N, N, N));
    repeat (3) @(posedge CLK);
    #1;
    for (int c = 0; c <= 17; c++) begin
      if (c == 1) RST_N = 1'b1;
      sb.push_back(ex(Y, N, 16'h0, Y, N, N, 2'b00, Y, (c < 17) ? Y : N));
      @(negedge CLK);
      e = sb.pop_front();
      checks++;
      if (bus.PredTaken !== e.pt || bus.PredTarget !== e.tgt)
        $display("FAIL reset step %0d fetch: got pt=%b tgt=%h want pt=%b tgt=%h",
                 c, bus.PredTaken, bus.PredTarget, e.pt, e.tgt);
      else passed++;
      checks++;
      if (bus.PcMatchValid !== e.pmv || bus.JumpTaken !== e.jt || bus.CtrlState !== e.cs)
        $display("FAIL reset step %0d pipe: got %b%b%b want %b%b%b", c,
                 bus.PcMatchValid, bus.JumpTaken, bus.CtrlState, e.pmv, e.jt, e.cs);
      else passed++;
      checks++;
      if (bus.Busy !== e.busy)
        $display("FAIL reset step %0d busy: got %b want %b", c, bus.Busy, e.busy);
      else passed++;
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_hit_alias();
    stim_t s[$];
    exp_t  x[$];
    exp_t  e;
    s.push_back(st(16'h0005, Y, 16'h0013, 16'h0040, 2'b10, N, N, N)); x.push_back(ex(Y, N, 16'h0,    N, N, N, 2'b00, Y, N));
    s.push_back(st(16'h0013, N, 16'h0,    16'h0,    2'b00, N, N, N)); x.push_back(ex(Y, Y, 16'h0040, Y, N, N, 2'b00, Y, N));
    s.push_back(st(16'h0023, N, 16'h0,    16'h0,    2'b00, N, N, N)); x.push_back(ex(Y, N, 16'h0,    Y, Y, Y, 2'b10, N, N));
    s.push_back(st(16'h0013, Y, 16'h0023, 16'h0055, 2'b01, N, N, N)); x.push_back(ex(Y, N, 16'h0,    Y, N, N, 2'b00, N, N));
    s.push_back(st(16'h0013, N, 16'h0,    16'h0,    2'b00, N, N, N)); x.push_back(ex(Y, N, 16'h0,    Y, N, N, 2'b00, N, N));
    s.push_back(st(16'h0023, N, 16'h0,    16'h0,    2'b00, N, N, N)); x.push_back(ex(Y, N, 16'h0055, Y, N, N, 2'b00, N, N));
    s.push_back(st(16'h0000, N, 16'h0,    16'h0,    2'b00, N, N, N)); x.push_back(ex(Y, N, 16'h0,    Y, Y, N, 2'b01, N, N));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      sb.push_back(x[i]);
      @(negedge CLK);
      e = sb.pop_front();
      if (e.cf) begin
        checks++;
        if (bus.PredTaken !== e.pt || bus.PredTarget !== e.tgt)
          $display("FAIL hit_alias step %0d fetch: got pt=%b tgt=%h want pt=%b tgt=%h",
                   i, bus.PredTaken, bus.PredTarget, e.pt, e.tgt);
        else passed++;
      end
      if (e.cp) begin
        checks++;
        if (bus.PcMatchValid !== e.pmv || bus.JumpTaken !== e.jt || bus.CtrlState !== e.cs)
          $display("FAIL hit_alias step %0d pipe: got %b%b%b want %b%b%b", i,
                   bus.PcMatchValid, bus.JumpTaken, bus.CtrlState, e.pmv, e.jt, e.cs);
        else passed++;
      end
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_bypass();
    stim_t s[$];
    exp_t  x[$];
    exp_t  e;
    s.push_back(st(16'h0007, Y, 16'h0007, 16'h0100, 2'b11, N, N, N)); x.push_back(ex(Y, Y, 16'h0100, N, N, N, 2'b00, Y, N));
    s.push_back(st(16'h0007, N, 16'h0,    16'h0,    2'b00, N, N, N)); x.push_back(ex(Y, Y, 16'h0100, Y, Y, Y, 2'b11, N, N));
    s.push_back(st(16'h0017, N, 16'h0,    16'h0,    2'b00, N, N, N)); x.push_back(ex(Y, N, 16'h0,    Y, Y, Y, 2'b11, N, N));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      sb.push_back(x[i]);
      @(negedge CLK);
      e = sb.pop_front();
      if (e.cf) begin
        checks++;
        if (bus.PredTaken !== e.pt || bus.PredTarget !== e.tgt)
          $display("FAIL bypass step %0d fetch: got pt=%b tgt=%h want pt=%b tgt=%h",
                   i, bus.PredTaken, bus.PredTarget, e.pt, e.tgt);
        else passed++;
      end
      if (e.cp) begin
        checks++;
        if (bus.PcMatchValid !== e.pmv || bus.JumpTaken !== e.jt || bus.CtrlState !== e.cs)
          $display("FAIL bypass step %0d pipe: got %b%b%b want %b%b%b", i,
                   bus.PcMatchValid, bus.JumpTaken, bus.CtrlState, e.pmv, e.jt, e.cs);
        else passed++;
      end
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_pipe_ctl();
    stim_t s[$];
    exp_t  x[$];
    exp_t  e;
    s.push_back(st(16'h0007, N, 16'h0, 16'h0, 2'b00, N, N, N)); x.push_back(ex(Y, Y, 16'h0100, Y, N, N, 2'b00, N, N));
    s.push_back(st(16'h0005, N, 16'h0, 16'h0, 2'b00, Y, Y, N)); x.push_back(ex(Y, N, 16'h0,    Y, Y, Y, 2'b11, N, N));
    s.push_back(st(16'h0007, N, 16'h0, 16'h0, 2'b00, N, N, N)); x.push_back(ex(Y, Y, 16'h0100, Y, N, N, 2'b00, N, N));
    s.push_back(st(16'h0005, N, 16'h0, 16'h0, 2'b00, Y, N, N)); x.push_back(ex(Y, N, 16'h0,    Y, Y, Y, 2'b11, N, N));
    s.push_back(st(16'h0005, N, 16'h0, 16'h0, 2'b00, Y, N, N)); x.push_back(ex(Y, N, 16'h0,    Y, Y, Y, 2'b11, N, N));
    s.push_back(st(16'h0005, N, 16'h0, 16'h0, 2'b00, N, N, N)); x.push_back(ex(Y, N, 16'h0,    Y, Y, Y, 2'b11, N, N));
    s.push_back(st(16'h0023, N, 16'h0, 16'h0, 2'b00, N, N, N)); x.push_back(ex(Y, N, 16'h0055, Y, N, N, 2'b00, N, N));
    s.push_back(st(16'h0000, N, 16'h0, 16'h0, 2'b00, N, N, N)); x.push_back(ex(Y, N, 16'h0,    Y, Y, N, 2'b01, N, N));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      sb.push_back(x[i]);
      @(negedge CLK);
      e = sb.pop_front();
      if (e.cf) begin
        checks++;
        if (bus.PredTaken !== e.pt || bus.PredTarget !== e.tgt)
          $display("FAIL pipe_ctl step %0d fetch: got pt=%b tgt=%h want pt=%b tgt=%h",
                   i, bus.PredTaken, bus.PredTarget, e.pt, e.tgt);
        else passed++;
      end
      if (e.cp) begin
        checks++;
        if (bus.PcMatchValid !== e.pmv || bus.JumpTaken !== e.jt || bus.CtrlState !== e.cs)
          $display("FAIL pipe_ctl step %0d pipe: got %b%b%b want %b%b%b", i,
                   bus.PcMatchValid, bus.JumpTaken, bus.CtrlState, e.pmv, e.jt, e.cs);
        else passed++;
      end
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_invalidate();
    stim_t s[$];
    exp_t  x[$];
    exp_t  e;
    // Third entry, then invalidate while it is visible.
    s.push_back(st(16'h000A, Y, 16'h000A, 16'h00AA, 2'b10, N, N, N)); x.push_back(ex(Y, Y, 16'h00AA, N, N, N, 2'b00, Y, N));
    s.push_back(st(16'h000A, N, 16'h0,    16'h0,    2'b00, N, N, Y)); x.push_back(ex(Y, Y, 16'h00AA, N, N, N, 2'b00, Y, N));
    for (int c = 0; c < 16; c++) begin
      s.push_back(st(16'h0007, Y, 16'h0001, 16'h0111, 2'b11, N, N, N));
      x.push_back(ex(Y, N, 16'h0, N, N, N, 2'b00, Y, Y));
    end
    s.push_back(st(16'h0007, N, 16'h0, 16'h0, 2'b00, N, N, N)); x.push_back(ex(Y, N, 16'h0, N, N, N, 2'b00, Y, N));
    s.push_back(st(16'h0023, N, 16'h0, 16'h0, 2'b00, N, N, N)); x.push_back(ex(Y, N, 16'h0, N, N, N, 2'b00, Y, N));
    s.push_back(st(16'h000A, N, 16'h0, 16'h0, 2'b00, N, N, N)); x.push_back(ex(Y, N, 16'h0, N, N, N, 2'b00, Y, N));
    s.push_back(st(16'h0001, N, 16'h0, 16'h0, 2'b00, N, N, N)); x.push_back(ex(Y, N, 16'h0, N, N, N, 2'b00, Y, N));
    // Restart the walk eight cycles in.
    s.push_back(st(16'h0005, N, 16'h0, 16'h0, 2'b00, N, N, Y)); x.push_back(ex(N, N, 16'h0, N, N, N, 2'b00, Y, N));
    for (int c = 0; c <= 25; c++) begin
      s.push_back(st(16'h0005, N, 16'h0, 16'h0, 2'b00, N, N, (c == 8) ? Y : N));
      x.push_back(ex(N, N, 16'h0, N, N, N, 2'b00, Y, (c < 25) ? Y : N));
    end
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      sb.push_back(x[i]);
      @(negedge CLK);
      e = sb.pop_front();
      if (e.cf) begin
        checks++;
        if (bus.PredTaken !== e.pt || bus.PredTarget !== e.tgt)
          $display("FAIL invalidate step %0d fetch: got pt=%b tgt=%h want pt=%b tgt=%h",
                   i, bus.PredTaken, bus.PredTarget, e.pt, e.tgt);
        else passed++;
      end
      if (e.cb) begin
        checks++;
        if (bus.Busy !== e.busy)
          $display("FAIL invalidate step %0d busy: got %b want %b", i, bus.Busy, e.busy);
        else passed++;
      end
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_hit_alias();
    test_bypass();
    test_pipe_ctl();
    test_invalidate();
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL scoreboard drain: got %0d entries left want 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
